iob_deser_n: RTL
================

# iob_deser_n

Serial-in, parallel-out deserializer that assembles `DATA_W` serial bits into one word and presents it on a one-word valid/ready output buffer. It sits directly upstream of the falling-edge capture register in the receive path. It runs on the rising edge of `clk_i`, so its `data_o` is stable for half a cycle before the downstream falling-edge capture.

## Interface
Parameters:
- `DATA_W`, default 8: word width; legal values are 2 and above.
- `RST_VAL`, default 0: reset value of the shift register and `data_o`, truncated to `DATA_W`.

Ports:
- `clk_i`, input, 1: clock; all state updates on the rising edge.
- `rst_n_i`, input, 1: reset, synchronous, active-low; overrides `ce_i`.
- `ce_i`, input, 1: clock enable; when 0, all state is frozen and `ser_ready_o` is 0.
- `ser_valid_i`, input, 1: serial bit valid.
- `ser_data_i`, input, 1: serial bit.
- `ser_ready_o`, output, 1: bit accepted at this edge if `ser_valid_i` is also 1.
- `data_o`, output, `DATA_W`: assembled word, registered.
- `data_valid_o`, output, 1: `data_o` holds an unconsumed word.
- `data_ready_i`, input, 1: consumer takes the word.
- `bit_cnt_o`, output, `$clog2(DATA_W)`: number of bits held in the shift register.

## Operation
- Definitions:
  - bit accept: `ce_i & ser_valid_i & ser_ready_o`.
  - word consume: `ce_i & data_valid_o & data_ready_i`.
  - last bit: a bit accept while `bit_cnt_o == DATA_W-1`.
- Output buffer FSM, two states:
  - EMPTY: `data_valid_o` = 0.
  - FULL: `data_valid_o` = 1.
- FSM transitions:
  - EMPTY to FULL on a last bit.
  - FULL to EMPTY on a word consume without a simultaneous last bit.
  - FULL stays FULL when a consume and a last bit occur at the same edge; `data_o` takes the new word.
- `ser_ready_o = ce_i & !(bit_cnt_o == DATA_W-1 & data_valid_o & !data_ready_i)`. Only the last bit stalls, and only while the buffer is full and not draining. Bits 0 to `DATA_W-2` are always accepted when `ce_i` is 1.
- Bit counter:
  - Increments on each bit accept.
  - Wraps from `DATA_W-1` to 0 on a last bit.
  - Never reaches `DATA_W`.
- Shift register:
  - Default (LSB first): the bit accepted with `bit_cnt_o == k` lands in bit k.
  - On a last bit, `data_o` is loaded with the completed word, including the last bit itself.
- `data_o` is held unchanged in EMPTY and keeps the last word consumed.
- Reset (`rst_n_i` = 0 at an edge):
  - `bit_cnt_o` = 0, `data_valid_o` = 0, `data_o` = `RST_VAL`, shift register = `RST_VAL`.
  - Reset in the middle of a word discards the partial bits.
  - Reset while FULL discards the word.
  - `ser_ready_o` follows its formula from the reset values, so it equals `ce_i`.
- Serial data is never lost silently: a stalled last bit stays pending until the buffer drains.

## Timing
- Latency: `data_valid_o` rises one cycle after the edge that accepts the last bit.
- Throughput: one bit per cycle sustained, provided the consumer takes each word within `DATA_W-1` cycles of `data_valid_o` rising.
- `ser_ready_o` has a combinational path from `data_ready_i`. There is no combinational path from `ser_valid_i`, `ser_data_i` or `data_ready_i` to any registered output.
- The downstream falling-edge register sees `data_o` and `data_valid_o` settled one half-cycle after the rising edge.
- When `ce_i` is 0, the FSM, counter, shift register and outputs hold their values.

## Configuration
- Macro: `IOB_DESER_MSB_FIRST_EN`.
- Undefined (default): LSB first; the first accepted bit becomes `data_o[0]`.
- Defined: MSB first; the shift register shifts left by one and inserts each bit at position 0, so the first bit accepted becomes `data_o[DATA_W-1]`.
- Handshake, counter and timing are identical in both builds.

## Structure
- Package `iob_deser_pkg` holds:
  - FSM state localparams: `DESER_EMPTY` = 1'b0, `DESER_FULL` = 1'b1.
  - Counter width function: `$clog2(DATA_W)`, minimum 1.
- Sub-module `iob_modcnt_n`: modulo-N up-counter with `clk_i`, `rst_n_i`, `ce_i`, `en_i`, `cnt_o` and `wrap_o`. It is instantiated with N = `DATA_W` as the bit counter.
- The shift register, the FSM and the `data_o` register stay in the top module.

## Test plan
All scenarios use `DATA_W` = 8 and `RST_VAL` = 0.
- Basic word:
  - Stimulus: `ser_valid_i`=1 for 8 cycles with bits 1,0,1,1,0,0,1,0 and `data_ready_i`=1.
  - Response: `data_o`=0x4D and `data_valid_o`=1 for one cycle, one cycle after the 8th bit. Rerun with `IOB_DESER_MSB_FIRST_EN` defined: `data_o`=0xB2.
- Backpressure:
  - Stimulus: `data_ready_i`=0, two back-to-back words 0xA5 then 0x3C.
  - Response: `ser_ready_o` drops while the 8th bit of 0x3C is presented. Raising `data_ready_i` for one cycle consumes 0xA5 and accepts the last bit at the same edge. Next cycle `data_o`=0x3C and `data_valid_o`=1. No bit is lost.
- Clock enable:
  - Stimulus: deassert `ce_i` for 5 cycles after bit 3, with `ser_valid_i`=1 throughout.
  - Response: `ser_ready_o`=0 and `bit_cnt_o` stays 3 during the gap. The word completes correctly after `ce_i` returns.
- Reset mid-word:
  - Stimulus: assert `rst_n_i`=0 for one cycle after 5 bits.
  - Response: `bit_cnt_o`=0 and `data_o`=0x00. The next 8 bits 0xFF yield `data_o`=0xFF.
- Reset while FULL:
  - Stimulus: reset with `data_valid_o`=1 and `data_ready_i`=0.
  - Response: `data_valid_o`=0 the next cycle and `ser_ready_o`=1.
- Continuous stream:
  - Stimulus: 64 random words at one bit per cycle, `data_ready_i`=1.
  - Response: all 64 words match a scoreboard; `ser_ready_o` never drops.

Source files
------------

// File: rtl/iob_deser_pkg.sv
// Shared definitions for the iob_deser_n serial-in, parallel-out deserializer.
package iob_deser_pkg;

    typedef enum logic {
        DESER_EMPTY = 1'b0,
        DESER_FULL  = 1'b1
    } deser_state_t;

    // Counter width for a modulo-n count, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/iob_modcnt_n.sv
// Modulo-N up-counter with clock enable; wrap_o flags the edge that returns the count to zero.
module iob_modcnt_n
    import iob_deser_pkg::*;
#(
    parameter int N = 8,
    parameter int W = cnt_w(N)
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         ce_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o
);

    localparam logic [W-1:0] CNT_MAX = W'(N - 1);

    assign wrap_o = ce_i & en_i & (cnt_o == CNT_MAX);

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            cnt_o <= '0;
        end else if (ce_i && en_i) begin
            cnt_o <= wrap_o ? '0 : cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/iob_deser_n.sv
// Deserializer with a one-word valid/ready output buffer; define IOB_DESER_MSB_FIRST_EN
// for MSB-first assembly (default is LSB first).
module iob_deser_n
    import iob_deser_pkg::*;
#(
    parameter int                 DATA_W  = 8,
    parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        ce_i,
    input  logic                        ser_valid_i,
    input  logic                        ser_data_i,
    output logic                        ser_ready_o,
    output logic [DATA_W-1:0]           data_o,
    output logic                        data_valid_o,
    input  logic                        data_ready_i,
    output logic [cnt_w(DATA_W)-1:0]    bit_cnt_o
);

    localparam int                CNT_W    = cnt_w(DATA_W);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

    deser_state_t       state;
    logic [DATA_W-1:0]  sreg;
    logic [DATA_W-1:0]  word_next;
    logic               at_last;
    logic               bit_acc;
    logic               last_bit;
    logic               consume;

    assign at_last      = (bit_cnt_o == LAST_CNT);
    assign data_valid_o = (state == DESER_FULL);
    // Only the final bit of a word can stall, and only while the held word is not draining.
    assign ser_ready_o  = ce_i & ~(at_last & data_valid_o & ~data_ready_i);
    assign bit_acc      = ser_valid_i & ser_ready_o;
    assign consume      = ce_i & data_valid_o & data_ready_i;

    iob_modcnt_n #(
        .N (DATA_W),
        .W (CNT_W)
    ) u_bit_cnt (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .ce_i    (ce_i),
        .en_i    (bit_acc),
        .cnt_o   (bit_cnt_o),
        .wrap_o  (last_bit)
    );

    // NOTE: default assignment first so no path through always_comb leaves word_next unassigned (no latch).
    always_comb begin
        word_next = sreg;
`ifdef IOB_DESER_MSB_FIRST_EN
        word_next = {sreg[DATA_W-2:0], ser_data_i};
`else
        word_next[bit_cnt_o] = ser_data_i;
`endif
    end

    // The completed word, including the bit accepted at this edge, goes straight to data_o.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state  <= DESER_EMPTY;
            sreg   <= RST_VAL;
            data_o <= RST_VAL;
        end else if (ce_i) begin
            if (bit_acc) begin
                sreg <= word_next;
            end
            if (last_bit) begin
                data_o <= word_next;
            end
            case (state)
                DESER_EMPTY: if (last_bit)             state <= DESER_FULL;
                DESER_FULL:  if (consume && !last_bit) state <= DESER_EMPTY;
                default:                               state <= DESER_EMPTY;
            endcase
        end
    end

endmodule
